// File: rtl/acf_pkg.sv
// rtl/acf_pkg.sv - shared state encoding and AXI-Lite constants for the acquisition sequencer
package acf_pkg;

   typedef logic [2:0] acf_state_t;

   localparam acf_state_t S_IDLE = 3'd0;
   localparam acf_state_t S_ARM  = 3'd1;
   localparam acf_state_t S_RUN  = 3'd2;
   localparam acf_state_t S_AR   = 3'd3;
   localparam acf_state_t S_R    = 3'd4;
   localparam acf_state_t S_PUSH = 3'd5;

   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam int         REG_STRIDE = 4;

endpackage

// File: rtl/acf_acq_sequencer_if.sv
// rtl/acf_acq_sequencer_if.sv - AXI4-Lite read address/data channels toward the ACF_AXI slave
interface acf_acq_sequencer_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] araddr;
   logic [2:0]        arprot;
   logic              arvalid;
   logic              arready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport master (
      output araddr, arprot, arvalid, rready,
      input  arready, rdata, rresp, rvalid
   );

   modport slave (
      input  araddr, arprot, arvalid, rready,
      output arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/acf_axil_rd_master.sv
// rtl/acf_axil_rd_master.sv - single-beat AXI4-Lite read engine: req/addr in, done/data/resp out
// done/data/resp are the live R-channel handshake so the caller can register the word without a bubble.
module acf_axil_rd_master #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [ADDR_W-1:0] addr,
   output logic              done,
   output logic [DATA_W-1:0] data,
   output logic [1:0]        resp,
   acf_acq_sequencer_if.master axi
);

   always_ff @(posedge clk) begin
      if (rst) begin
         axi.araddr  <= '0;
         axi.arvalid <= 1'b0;
         axi.rready  <= 1'b0;
      end else begin
         // A request is only accepted while no beat is outstanding.
         if (req && !axi.arvalid && !axi.rready) begin
            axi.araddr  <= addr;
            axi.arvalid <= 1'b1;
         end
         if (axi.arvalid && axi.arready) begin
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b1;
         end
         if (axi.rready && axi.rvalid) begin
            axi.rready <= 1'b0;
         end
      end
   end

   assign axi.arprot = 3'b000;
   assign done       = axi.rready && axi.rvalid;
   assign data       = axi.rdata;
   assign resp       = axi.rresp;

endmodule

// File: rtl/acf_acq_sequencer.sv
// rtl/acf_acq_sequencer.sv - runs one ACF_AXI counting window, then streams NUM_REGS result words out
module acf_acq_sequencer
   import acf_pkg::*;
#(
   parameter int CNTR_SIZE        = 32,
   parameter int C_AXI_ADDR_WIDTH = 32,
   parameter int C_AXI_DATA_WIDTH = 32,
   parameter int NUM_REGS         = 4,
   parameter logic [C_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
   input  logic                 aclk,
   input  logic                 arst,
   input  logic                 start,
   input  logic                 stop,
   input  logic [CNTR_SIZE-1:0] window_len,
   output logic                 CE,
   output logic                 initTX,
   output logic [CNTR_SIZE-1:0] presentTime,
   acf_acq_sequencer_if.master  m_axi,
   output logic [31:0]          out_data,
   output logic [3:0]           out_idx,
   output logic                 out_err,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy,
   output logic [15:0]          win_count
);

   localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

   acf_state_t                  state;
   logic [3:0]                  idx;
   logic                        stop_pend;
   logic [CNTR_SIZE-1:0]        win_len;

   logic                        pt_last;
   logic                        last_idx;
   logic                        rd_req;
   logic [3:0]                  req_idx;
   logic [C_AXI_ADDR_WIDTH-1:0] req_addr;
   logic                        rd_done;
   logic [C_AXI_DATA_WIDTH-1:0] rd_data;
   logic [1:0]                  rd_resp;

   assign pt_last  = (presentTime == win_len - CNTR_SIZE'(1));
   assign last_idx = (idx == LAST_IDX);

   // The read is launched on the same edge that enters AR, so arvalid is high for the whole AR state.
   assign rd_req   = ((state == S_RUN) && pt_last) ||
                     ((state == S_PUSH) && out_ready && !last_idx);
   assign req_idx  = (state == S_PUSH) ? idx + 4'd1 : 4'd0;
   assign req_addr = BASE_ADDR + (C_AXI_ADDR_WIDTH'(req_idx) * C_AXI_ADDR_WIDTH'(REG_STRIDE));

   acf_axil_rd_master #(
      .ADDR_W (C_AXI_ADDR_WIDTH),
      .DATA_W (C_AXI_DATA_WIDTH)
   ) u_rd (
      .clk  (aclk),
      .rst  (arst),
      .req  (rd_req),
      .addr (req_addr),
      .done (rd_done),
      .data (rd_data),
      .resp (rd_resp),
      .axi  (m_axi)
   );

   always_ff @(posedge aclk) begin
      if (arst) begin
         state       <= S_IDLE;
         idx         <= 4'd0;
         stop_pend   <= 1'b0;
         win_len     <= '0;
         CE          <= 1'b0;
         initTX      <= 1'b0;
         presentTime <= '0;
         out_data    <= 32'd0;
         out_idx     <= 4'd0;
         out_err     <= 1'b0;
         out_valid   <= 1'b0;
         busy        <= 1'b0;
         win_count   <= 16'd0;
      end else begin
         if (stop && (state != S_IDLE)) begin
            stop_pend <= 1'b1;
         end
         case (state)
            S_IDLE: begin
               if (start) begin
                  state  <= S_ARM;
                  initTX <= 1'b1;
                  busy   <= 1'b1;
               end
            end
            S_ARM: begin
               initTX      <= 1'b0;
               presentTime <= '0;
               CE          <= 1'b1;
               win_len     <= (window_len == '0) ? CNTR_SIZE'(1) : window_len;
               state       <= S_RUN;
            end
            S_RUN: begin
               if (pt_last) begin
                  CE    <= 1'b0;
                  idx   <= 4'd0;
                  state <= S_AR;
               end else begin
                  presentTime <= presentTime + CNTR_SIZE'(1);
               end
            end
            S_AR: begin
               if (m_axi.arvalid && m_axi.arready) begin
                  state <= S_R;
               end
            end
            S_R: begin
               if (rd_done) begin
                  out_data  <= rd_data;
                  out_idx   <= idx;
                  out_err   <= (rd_resp != RESP_OKAY);
                  out_valid <= 1'b1;
                  state     <= S_PUSH;
               end
            end
            S_PUSH: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (!last_idx) begin
                     idx   <= idx + 4'd1;
                     state <= S_AR;
                  end else begin
                     win_count <= win_count + 16'd1;
                     idx       <= 4'd0;
                     if (stop_pend) begin
                        stop_pend <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                     end else begin
                        initTX <= 1'b1;
                        state  <= S_ARM;
                     end
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_acf_acq_sequencer.sv
// tb/tb_acf_acq_sequencer.sv - directed and randomized windows checked against a word-queue reference model
module tb_acf_acq_sequencer;

   localparam int          NREG = 4;
   localparam logic [31:0] BASE = 32'h0000_0040;

   logic        aclk = 1'b0;
   logic        arst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [31:0] window_len = 32'd0;
   logic        CE;
   logic        initTX;
   logic [31:0] presentTime;
   logic [31:0] out_data;
   logic [3:0]  out_idx;
   logic        out_err;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        busy;
   logic [15:0] win_count;

   acf_acq_sequencer_if #(.ADDR_W(32), .DATA_W(32)) axi ();

   acf_acq_sequencer #(
      .CNTR_SIZE        (32),
      .C_AXI_ADDR_WIDTH (32),
      .C_AXI_DATA_WIDTH (32),
      .NUM_REGS         (NREG),
      .BASE_ADDR        (BASE)
   ) dut (
      .aclk        (aclk),
      .arst        (arst),
      .start       (start),
      .stop        (stop),
      .window_len  (window_len),
      .CE          (CE),
      .initTX      (initTX),
      .presentTime (presentTime),
      .m_axi       (axi),
      .out_data    (out_data),
      .out_idx     (out_idx),
      .out_err     (out_err),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .busy        (busy),
      .win_count   (win_count)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int errors = 0;
   int inits = 0;
   int words = 0;
   int ar_delay = 0;
   int r_delay = 0;
   int sink_delay = 0;
   int err_idx = -1;
   logic [31:0] mem [16];
   logic [36:0] exp_q [$];

   int          sl_st = 0;
   int          ar_cnt = 0;
   int          r_cnt = 0;
   int          rd_k = 0;
   logic        addr_seen = 1'b0;
   logic [31:0] held_addr = 32'd0;
   logic        hold_act = 1'b0;
   logic [36:0] held_w = '0;
   int          sink_cnt = 0;
   int          ce_run = 0;
   logic        prev_init = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Slave, sink and window monitor, evaluated once per falling edge.
   task automatic step_models();
      logic [36:0] w;
      if (arst) begin
         axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = 32'd0; axi.rresp = 2'b00;
         sl_st = 0; ar_cnt = 0; r_cnt = 0; rd_k = 0; addr_seen = 1'b0;
         out_ready = 1'b0; hold_act = 1'b0; sink_cnt = 0;
         ce_run = 0; prev_init = 1'b0;
         return;
      end
      if (prev_init) check("inittx_pulse", initTX, 0);
      if (initTX && !prev_init) begin
         inits++;
         check("ce_at_init", CE, 0);
         for (int k = 0; k < NREG; k++) exp_q.push_back({4'(k), (k == err_idx), mem[k]});
      end
      prev_init = initTX;
      if (CE) begin
         check("pt", presentTime, ce_run);
         ce_run++;
      end else if (ce_run != 0) begin
         check("ce_len", ce_run, (window_len == 0) ? 32'd1 : window_len);
         ce_run = 0;
      end
      case (sl_st)
         0: if (axi.arvalid) begin
            if (addr_seen) check("araddr_stable", axi.araddr, held_addr);
            else begin held_addr = axi.araddr; addr_seen = 1'b1; end
            if (ar_cnt >= ar_delay) begin
               check("araddr", axi.araddr, BASE + 32'(4 * rd_k));
               axi.arready = 1'b1; sl_st = 1; ar_cnt = 0; addr_seen = 1'b0;
            end else ar_cnt++;
         end
         1: begin
            axi.arready = 1'b0;
            if (r_cnt == 0) check("rready", {axi.rready, axi.arvalid}, 2'b10);
            if (r_cnt >= r_delay) begin
               axi.rvalid = 1'b1; axi.rdata = mem[rd_k];
               axi.rresp = (rd_k == err_idx) ? 2'b10 : 2'b00;
               sl_st = 2; r_cnt = 0;
            end else r_cnt++;
         end
         default: begin
            axi.rvalid = 1'b0; rd_k = (rd_k + 1) % NREG; sl_st = 0;
         end
      endcase
      if (out_valid) begin
         if (hold_act) check("out_stable", {out_idx, out_err, out_data}, held_w);
         else begin held_w = {out_idx, out_err, out_data}; hold_act = 1'b1; end
         if (sink_cnt >= sink_delay) begin
            out_ready = 1'b1;
            check("word_avail", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               w = exp_q.pop_front();
               check("out_idx", out_idx, w[36:33]);
               check("out_err", out_err, w[32]);
               check("out_data", out_data, w[31:0]);
            end
            words++; hold_act = 1'b0; sink_cnt = 0;
         end else begin
            out_ready = 1'b0; sink_cnt++;
         end
      end else out_ready = 1'b0;
   endtask

   task automatic tick();
      @(negedge aclk);
      step_models();
   endtask

   task automatic wait_ce(input logic v);
      int n = 0;
      while (CE !== v && n < 400) begin tick(); n++; end
      check("wait_ce", CE, v);
   endtask

   task automatic check_reset(input string p);
      check({p, "_busy"}, busy, 0);
      check({p, "_ce"}, {CE, initTX}, 0);
      check({p, "_pt"}, presentTime, 0);
      check({p, "_axi"}, {axi.arvalid, axi.rready, axi.arprot}, 0);
      check({p, "_araddr"}, axi.araddr, 0);
      check({p, "_out"}, {out_valid, out_err, out_idx, out_data}, 0);
      check({p, "_wincnt"}, win_count, 0);
   endtask

   task automatic run_windows(input int wl, input int nwin, input logic stop_at_start);
      int base_wc, base_inits, base_words, n;
      window_len = 32'(wl);
      base_wc = int'(win_count); base_inits = inits; base_words = words;
      tick(); start = 1'b1; stop = stop_at_start;
      tick(); start = 1'b0; stop = 1'b0;
      for (int w = 1; w <= nwin; w++) begin
         wait_ce(1'b1);
         if (w == nwin) begin stop = 1'b1; tick(); stop = 1'b0; end
         else wait_ce(1'b0);
      end
      n = 0;
      while (busy !== 1'b0 && n < 1000) begin tick(); n++; end
      check("idle", busy, 0);
      repeat (3) tick();
      check("win_count", win_count, 16'(base_wc + nwin));
      check("windows", inits - base_inits, nwin);
      check("words", words - base_words, nwin * NREG);
      check("q_empty", exp_q.size(), 0);
   endtask

   initial begin
      int n, e;
      for (int k = 0; k < 16; k++) mem[k] = 32'h10 + 32'(k);
      repeat (3) tick();
      check_reset("rst");
      arst = 1'b0;
      tick();

      // stop in IDLE is ignored, and stop alongside start loses to start
      stop = 1'b1; tick(); stop = 1'b0;
      run_windows(5, 2, 1'b1);

      run_windows(5, 1, 1'b0);

      ar_delay = 3; r_delay = 2; sink_delay = 4;
      for (int k = 0; k < NREG; k++) mem[k] = $urandom;
      run_windows(4, 1, 1'b0);

      ar_delay = 0; r_delay = 0; sink_delay = 0;
      run_windows(0, 1, 1'b0);

      err_idx = 2;
      run_windows(3, 1, 1'b0);

      for (int t = 0; t < 6; t++) begin
         ar_delay = $urandom_range(0, 3);
         r_delay = $urandom_range(0, 3);
         sink_delay = $urandom_range(0, 4);
         e = $urandom_range(0, NREG);
         err_idx = (e == NREG) ? -1 : e;
         for (int k = 0; k < NREG; k++) mem[k] = $urandom;
         run_windows($urandom_range(0, 9), $urandom_range(1, 2), 1'b0);
      end

      // reset while an address beat is stalled
      err_idx = -1; ar_delay = 20; sink_delay = 0;
      window_len = 32'd3;
      tick(); start = 1'b1; tick(); start = 1'b0;
      n = 0;
      while (axi.arvalid !== 1'b1 && n < 100) begin tick(); n++; end
      check("arvalid_before_rst", axi.arvalid, 1);
      tick();
      arst = 1'b1;
      tick();
      check_reset("midrst");
      arst = 1'b0;
      exp_q.delete();
      ar_delay = 0;
      run_windows(3, 1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
